// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response and decode handoff bundle
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata,
        output instr_valid, instr, instr_pc, instr_pcplus4,
        input  instr_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata,
        input  instr_valid, instr, instr_pc, instr_pcplus4,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with one-in-flight request and small instruction queue
// Optional FETCH_MISALIGN_CHK_EN: misaligned redirect raises sticky fetch_fault and halts fetch.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic         fetch_fault
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] QD = QDEPTH[CW:0];

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          outstanding;
    logic          discard;
    logic          halted;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   q_pc    [QDEPTH];
    logic [31:0]   q_instr [QDEPTH];

    logic          pop;
    logic          resp;
    logic          push;
    logic          accept;
    logic          head_valid;
    logic [CW:0]   occupancy;

    assign head_valid = (count != '0) & ~halted;
    assign pop        = head_valid & bus.instr_ready;
    assign resp       = outstanding & bus.imem_rvalid;
    // A response landing in a redirect cycle belongs to the old path and is dropped.
    assign push       = resp & ~discard & ~redirect;
    assign occupancy  = {1'b0, count} + {{CW{1'b0}}, outstanding} - {{CW{1'b0}}, pop};

    assign bus.imem_req  = rst_n & ~redirect & ~halted & (~outstanding | bus.imem_rvalid)
                         & (occupancy < QD);
    assign bus.imem_addr = fetch_pc;
    assign accept        = bus.imem_req & bus.imem_ready;

    assign bus.instr_valid   = head_valid;
    assign bus.instr         = head_valid ? q_instr[rd_ptr] : 32'h0;
    assign bus.instr_pc      = head_valid ? q_pc[rd_ptr] : 32'h0;
    assign bus.instr_pcplus4 = bus.instr_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= 32'h0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect) begin
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            outstanding <= outstanding & ~bus.imem_rvalid;
            discard     <= outstanding & ~bus.imem_rvalid;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (accept) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
                outstanding <= 1'b1;
            end else if (resp) begin
                outstanding <= 1'b0;
            end
            if (resp && discard) begin
                discard <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= inflight_pc;
            q_instr[wr_ptr] <= bus.imem_rdata;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            halted <= 1'b1;
        end
    end

    assign fetch_fault = halted;
`else
    logic unused_low_bits;

    assign halted          = 1'b0;
    assign fetch_fault     = 1'b0;
    assign unused_low_bits = ^redirect_pc[1:0];
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          overflow_cnt = 0;
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_lat;
    int          fixed_lat;
    bit          rand_mode;

    always @(posedge clk) begin
        if (rst_n && dut.push && !dut.pop && dut.count == 2'd2) begin
            overflow_cnt <= overflow_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (passed %0d of %0d)", n_pass, n_total);
        $fatal(1);
    end

    // Memory outputs for the current cycle; DUT combinational outputs are settled on return.
    task automatic drive_mem();
        if (mem_busy && mem_lat == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_addr ^ KEY;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
        end
        bus.imem_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
    endtask

    task automatic finish_cycle();
        if (bus.imem_rvalid) mem_busy = 1'b0;
        else if (mem_busy) mem_lat--;
        if (bus.imem_req && bus.imem_ready) begin
            mem_busy = 1'b1;
            mem_addr = bus.imem_addr;
            mem_lat  = rand_mode ? int'($urandom_range(0, 3)) : fixed_lat;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        bus.instr_ready = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        mem_busy        = 1'b0;
        mem_lat         = 0;
        fixed_lat       = 0;
        rand_mode       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        bus.instr_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive_mem();
            finish_cycle();
        end
        rst_n = 1'b0;
        bus.imem_ready = 1'b1;
        #1;
        n_total++;
        if ({bus.instr_valid, bus.imem_req, bus.instr, bus.instr_pc, bus.instr_pcplus4, fetch_fault}
            !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0})
            $display("FAIL reset_mid: valid=%0b req=%0b instr=%h pc=%h p4=%h fault=%0b, need 0 0 0 0 4 0",
                     bus.instr_valid, bus.imem_req, bus.instr, bus.instr_pc, bus.instr_pcplus4, fetch_fault);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({bus.imem_req, dut.fetch_pc, dut.count, dut.outstanding} !== {1'b0, 32'h0, 2'd0, 1'b0})
            $display("FAIL reset_state: req=%0b fetch_pc=%h count=%0d outstanding=%0b, need 0 0 0 0",
                     bus.imem_req, dut.fetch_pc, dut.count, dut.outstanding);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] pc;
        apply_reset();
        bus.instr_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            drive_mem();
            n_total++;
            if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'(c * 4)})
                $display("FAIL stream_req c%0d: req=%0b addr=%h, need 1 %h", c, bus.imem_req, bus.imem_addr, 32'(c * 4));
            else n_pass++;
            if (c < 2) begin
                n_total++;
                if (bus.instr_valid !== 1'b0)
                    $display("FAIL stream_early_valid c%0d: valid=%0b, need 0", c, bus.instr_valid);
                else n_pass++;
            end else begin
                pc = 32'((c - 2) * 4);
                n_total++;
                if ({bus.instr_valid, bus.instr_pc, bus.instr, bus.instr_pcplus4} !== {1'b1, pc, pc ^ KEY, pc + 32'd4})
                    $display("FAIL stream_head c%0d: valid=%0b pc=%h instr=%h p4=%h, need 1 %h %h %h",
                             c, bus.instr_valid, bus.instr_pc, bus.instr, bus.instr_pcplus4, pc, pc ^ KEY, pc + 32'd4);
                else n_pass++;
            end
            finish_cycle();
        end
    endtask

    task automatic test_stall();
        logic [31:0] pc;
        apply_reset();
        bus.instr_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive_mem();
            if (c == 9) begin
                n_total++;
                if ({bus.imem_req, dut.count, bus.instr_valid, bus.instr_pc} !== {1'b0, 2'd2, 1'b1, 32'h0})
                    $display("FAIL stall_full: req=%0b count=%0d valid=%0b pc=%h, need 0 2 1 0",
                             bus.imem_req, dut.count, bus.instr_valid, bus.instr_pc);
                else n_pass++;
            end
            finish_cycle();
        end
        bus.instr_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_mem();
            pc = 32'(c * 4);
            n_total++;
            if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, pc, pc ^ KEY})
                $display("FAIL stall_release r%0d: valid=%0b pc=%h instr=%h, need 1 %h %h",
                         c, bus.instr_valid, bus.instr_pc, bus.instr, pc, pc ^ KEY);
            else n_pass++;
            finish_cycle();
        end
    endtask

    task automatic test_redirect_inflight();
        bit          found;
        int          got;
        int          stale;
        logic [31:0] exp;
        apply_reset();
        fixed_lat       = 2;
        bus.instr_ready = 1'b1;
        found           = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            drive_mem();
            if (bus.imem_req && bus.imem_ready && bus.imem_addr == 32'h10) found = 1'b1;
            finish_cycle();
        end
        n_total++;
        if (!found) $display("FAIL redir_inflight_issue: request to 0x10 not seen within 60 cycles, need it");
        else n_pass++;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        drive_mem();
        n_total++;
        if (bus.imem_req !== 1'b0)
            $display("FAIL redir_inflight_noreq: req=%0b in redirect cycle, need 0", bus.imem_req);
        else n_pass++;
        finish_cycle();
        redirect = 1'b0;
        got      = 0;
        stale    = 0;
        exp      = 32'h100;
        for (int c = 0; c < 40 && got < 3; c++) begin
            drive_mem();
            if (bus.instr_valid && bus.instr_ready) begin
                if (bus.instr_pc == 32'h10) stale++;
                n_total++;
                if ({bus.instr_pc, bus.instr} !== {exp, exp ^ KEY})
                    $display("FAIL redir_inflight_seq %0d: pc=%h instr=%h, need %h %h",
                             got, bus.instr_pc, bus.instr, exp, exp ^ KEY);
                else n_pass++;
                exp += 32'd4;
                got++;
            end
            finish_cycle();
        end
        n_total++;
        if (got !== 3 || stale !== 0)
            $display("FAIL redir_inflight_count: delivered=%0d stale=%0d, need 3 0", got, stale);
        else n_pass++;
    endtask

    task automatic test_redirect_same_cycle();
        apply_reset();
        bus.instr_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_mem();
            finish_cycle();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        drive_mem();
        n_total++;
        if ({bus.imem_rvalid, bus.instr_valid, bus.imem_req} !== 3'b110)
            $display("FAIL same_cycle_setup: rvalid=%0b valid=%0b req=%0b, need 1 1 0",
                     bus.imem_rvalid, bus.instr_valid, bus.imem_req);
        else n_pass++;
        finish_cycle();
        redirect = 1'b0;
        drive_mem();
        n_total++;
        if ({bus.instr_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h200})
            $display("FAIL same_cycle_after: valid=%0b req=%0b addr=%h, need 0 1 00000200",
                     bus.instr_valid, bus.imem_req, bus.imem_addr);
        else n_pass++;
        finish_cycle();
        drive_mem();
        n_total++;
        if (bus.instr_valid !== 1'b0)
            $display("FAIL same_cycle_r2: valid=%0b, need 0", bus.instr_valid);
        else n_pass++;
        finish_cycle();
        drive_mem();
        n_total++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 32'h200, 32'h200 ^ KEY})
            $display("FAIL same_cycle_r3: valid=%0b pc=%h instr=%h, need 1 00000200 %h",
                     bus.instr_valid, bus.instr_pc, bus.instr, 32'h200 ^ KEY);
        else n_pass++;
        finish_cycle();
    endtask

    task automatic test_random();
        logic [31:0] exp;
        int          pops;
        apply_reset();
        rand_mode = 1'b1;
        exp       = 32'h0;
        pops      = 0;
        for (int c = 0; c < 600; c++) begin
            bus.instr_ready = 1'($urandom_range(0, 1));
            redirect        = ($urandom_range(0, 15) == 0);
            if (redirect) redirect_pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            drive_mem();
            if (!redirect && bus.instr_valid && bus.instr_ready) begin
                n_total++;
                if ({bus.instr_pc, bus.instr} !== {exp, exp ^ KEY})
                    $display("FAIL random_stream c%0d: pc=%h instr=%h, need %h %h",
                             c, bus.instr_pc, bus.instr, exp, exp ^ KEY);
                else n_pass++;
                exp += 32'd4;
                pops++;
            end
            if (redirect) exp = redirect_pc;
            finish_cycle();
        end
        redirect  = 1'b0;
        rand_mode = 1'b0;
        n_total++;
        if (pops < 40) $display("FAIL random_progress: delivered=%0d, need at least 40", pops);
        else n_pass++;
    endtask

    task automatic test_wrap();
        apply_reset();
        bus.instr_ready = 1'b1;
        redirect        = 1'b1;
        redirect_pc     = 32'hFFFF_FFFC;
        drive_mem();
        finish_cycle();
        redirect = 1'b0;
        drive_mem();
        n_total++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'hFFFF_FFFC})
            $display("FAIL wrap_req_top: req=%0b addr=%h, need 1 fffffffc", bus.imem_req, bus.imem_addr);
        else n_pass++;
        finish_cycle();
        drive_mem();
        n_total++;
        if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0})
            $display("FAIL wrap_req_zero: req=%0b addr=%h, need 1 00000000", bus.imem_req, bus.imem_addr);
        else n_pass++;
        finish_cycle();
        drive_mem();
        n_total++;
        if ({bus.instr_valid, bus.instr_pc, bus.instr, bus.instr_pcplus4} !== {1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 32'h0})
            $display("FAIL wrap_head: valid=%0b pc=%h instr=%h p4=%h, need 1 fffffffc 5a5afffc 00000000",
                     bus.instr_valid, bus.instr_pc, bus.instr, bus.instr_pcplus4);
        else n_pass++;
        finish_cycle();
    endtask

    task automatic test_misalign();
        apply_reset();
        bus.instr_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_mem();
            finish_cycle();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0102;
        drive_mem();
        finish_cycle();
        redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        for (int c = 0; c < 5; c++) begin
            drive_mem();
            n_total++;
            if ({fetch_fault, bus.imem_req, bus.instr_valid} !== 3'b100)
                $display("FAIL misalign_halt c%0d: fault=%0b req=%0b valid=%0b, need 1 0 0",
                         c, fetch_fault, bus.imem_req, bus.instr_valid);
            else n_pass++;
            finish_cycle();
        end
`else
        drive_mem();
        n_total++;
        if ({fetch_fault, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h100})
            $display("FAIL misalign_resume: fault=%0b req=%0b addr=%h, need 0 1 00000100",
                     fetch_fault, bus.imem_req, bus.imem_addr);
        else n_pass++;
        finish_cycle();
        drive_mem();
        finish_cycle();
        drive_mem();
        n_total++;
        if ({bus.instr_valid, bus.instr_pc} !== {1'b1, 32'h100})
            $display("FAIL misalign_head: valid=%0b pc=%h, need 1 00000100", bus.instr_valid, bus.instr_pc);
        else n_pass++;
        finish_cycle();
`endif
    endtask

    task automatic test_no_overflow();
        n_total++;
        if (overflow_cnt !== 0)
            $display("FAIL queue_overflow: pushes into full queue=%0d, need 0", overflow_cnt);
        else n_pass++;
    endtask

    initial begin
        rst_n           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 32'h0;
        bus.instr_ready = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_same_cycle();
        test_random();
        test_wrap();
        test_misalign();
        test_no_overflow();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the main decoder. Holds the fetch PC, issues word requests to instruction memory over a request/response handshake, and buffers returned instructions in a small FIFO. Presents `instr` together with its PC and PC+4 to decode with a valid/ready handshake. Flushes and restarts on a branch or jump redirect from the execute stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `QDEPTH`, default 2: instruction queue entries; power of two, at least 2.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: word-aligned request address.
- `imem_ready` in 1: memory accepts the request this cycle (handshake when `imem_req & imem_ready`).
- `imem_rvalid` in 1: response valid; responses return in order, at least 1 cycle after acceptance.
- `imem_rdata` in 32: response instruction word.
- `redirect` in 1: taken branch or jump this cycle.
- `redirect_pc` in 32: target PC (PCTarget or ALU result for jalr).
- `instr_valid` out 1: queue head valid.
- `instr_ready` in 1: decode consumes the head (pop when valid & ready).
- `instr` out 32: head instruction; decode takes op from [6:0] and funct3 from [14:12].
- `instr_pc` out 32: PC of the head instruction.
- `instr_pcplus4` out 32: `instr_pc + 4`, modulo 2^32.
- `fetch_fault` out 1: sticky misaligned-redirect flag (see Configuration).

## Operation
- State:
  - `fetch_pc`: next address to request.
  - `outstanding`: 1 bit; at most one request in flight.
  - `inflight_pc`: address of the request in flight.
  - `discard`: 1 bit; drop the next response.
  - Queue of {pc, instr} entries, with `count` in 0..QDEPTH.
- Issue condition: `imem_req = ~redirect & ~halted & (~outstanding | imem_rvalid) & (count + outstanding - pop < QDEPTH)`, where `pop = instr_valid & instr_ready`.
  - `imem_addr = fetch_pc`.
- On accept:
  - `inflight_pc <= fetch_pc`.
  - `fetch_pc <= fetch_pc + 4` (wraps at 2^32).
  - `outstanding <= 1`.
- On `imem_rvalid` with `outstanding`:
  - If `~discard`, push {inflight_pc, imem_rdata}.
  - Otherwise clear `discard` and push nothing.
  - `outstanding` clears unless a new request is accepted in the same cycle.
- `imem_rvalid` while `~outstanding` is ignored.
- On `redirect`:
  - Queue is flushed (`count <= 0`, pointers reset); `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - No request is issued that cycle.
  - If a request is in flight and its response is not arriving this same cycle, set `discard`.
  - A response arriving in the redirect cycle is dropped.
  - A pop in the same cycle has no further effect; the flush wins.
- Overflow is impossible by construction; a push into a full queue is a design error, and the bench asserts it never happens.
- `instr_pcplus4` is computed combinationally from the head PC.

## Timing
- Reset values:
  - `fetch_pc = RESET_PC`; `outstanding`, `discard`, `count`, `fetch_fault` = 0.
  - `instr_valid = 0`; `instr`, `instr_pc` = 0; `instr_pcplus4 = 4`.
  - `imem_req` is low during reset.
- Reset asserted mid-operation clears all state immediately; in-flight responses after reset release are ignored by the `outstanding = 0` rule.
- First cycle after reset release: `imem_req = 1`, `imem_addr = RESET_PC`.
- Latency: accept at edge k, rvalid in cycle k+1, push at edge k+1, `instr_valid` high in cycle k+2.
- Throughput: with single-cycle memory and decode always ready, one instruction per cycle.
- Redirect at edge r: the first request to the target issues in cycle r+1, and the first target instruction is valid at r+3 at the earliest.
- Decode stall (`instr_ready = 0`): queue fills to QDEPTH, then `imem_req` stays low. Head outputs hold stable until popped.

## Configuration
- Macro: `FETCH_MISALIGN_CHK_EN`.
- Defined:
  - A redirect with `redirect_pc[1:0] != 0` sets `fetch_fault`, flushes, and sets `halted`.
  - `fetch_fault` and `halted` are sticky until reset.
  - No further requests issue and `instr_valid` stays 0.
- Undefined:
  - `fetch_fault` is tied to 0 and `halted` is constant 0.
  - Low redirect bits are silently cleared.

## Test plan
- Reset release, single-cycle memory returning `addr^32'hA5A5_0000`, decode always ready: addresses 0, 4, 8… issued on consecutive cycles. `instr_pc` = 0, 4, 8 with matching data, `instr_valid` first high in cycle 2.
- Decode holds `instr_ready = 0` for 10 cycles: exactly 2 entries buffered, `imem_req` low. On release, pcs 0 and 4 delivered in order with no gap, then 8.
- Redirect to 32'h0000_0100 while a request to 0x10 is in flight and its response returns 3 cycles later: the 0x10 word never appears. The next `instr_pc` is 0x100, with 0x104 and 0x108 following.
- Redirect in the same cycle as `imem_rvalid` and a pop: queue empty next cycle, response dropped, next request address is the target.
- Memory with random 1–4 cycle latency and random `imem_ready`: `instr_pc` stream is strictly +4 between redirects, with no duplicates and no losses.
- Redirect to 32'h0000_0102:
  - With `FETCH_MISALIGN_CHK_EN`: `fetch_fault = 1`, no further `imem_req`.
  - Without it: fetch resumes at 0x100.
- `fetch_pc = 32'hFFFF_FFFC`: next request at 0; `instr_pcplus4 = 0` for that head.
